// File: rtl/dip_input_pkg.sv
// Shared constants and helpers for the DIP/switch input conditioner.
// Holds the word widths, the event kind encodings and the bit positions of
// the fields inside a 4-bit event word {kind, idx[2:0]}.
package dip_input_pkg;

    localparam int DIP_WIDTH = 16;
    localparam int SW_COUNT  = 5;
    localparam int EV_WIDTH  = 4;

    localparam logic EV_PRESS   = 1'b1;
    localparam logic EV_RELEASE = 1'b0;

    // Event field slices
    localparam int EV_KIND_BIT = 3;
    localparam int EV_IDX_MSB  = 2;
    localparam int EV_IDX_LSB  = 0;
    localparam int EV_IDX_W    = EV_IDX_MSB - EV_IDX_LSB + 1;

    typedef logic [EV_WIDTH-1:0] event_t;

    function automatic event_t make_event(input logic kind,
                                          input logic [EV_IDX_W-1:0] idx);
        event_t ev;
        ev = '0;
        ev[EV_KIND_BIT] = kind;
        ev[EV_IDX_MSB:EV_IDX_LSB] = idx;
        return ev;
    endfunction

endpackage

// File: rtl/dip_event_fifo.sv
// Synchronous FIFO with a valid/ready style head.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset (clears occupancy)
//   push         : write request; ignored while full, even if a pop happens
//   push_data    : word to write
//   ready        : consumer takes the head when the FIFO is not empty
//   head         : oldest entry, forced to 0 while empty
//   full, empty  : occupancy flags
// DEPTH must be a power of two and at least 2 so the pointers wrap naturally.
module dip_event_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             ready,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == DEPTH_CNT);
    assign empty   = (count == '0);
    // Gate the head so the output reads 0 whenever nothing is queued,
    // which also makes it clear immediately on reset.
    assign head    = empty ? '0 : mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = !empty && ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: it is only visible through the gated head.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/dip_input_conditioner.sv
// Debounces the DIP word and push-switches from the serial DIP parallelizer
// and turns switch transitions into press/release events.
// Ports:
//   i_CLK, i_RESET_n          : clock, asynchronous active-low reset
//   i_DIP16, i_Switch5        : raw parallelizer outputs
//   o_DIP16, o_Switch5        : debounced values
//   o_DIPChanged              : one-cycle pulse when o_DIP16 takes a new value
//   o_EvValid/o_EvData/i_EvReady : event FIFO head, {kind, idx}
//   o_EvOverflow              : one-cycle pulse when a switch event is lost
module dip_input_conditioner
    import dip_input_pkg::*;
#(
    parameter int SAMPLE_DIV     = 24,
    parameter int STABLE_SAMPLES = 4,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                 i_CLK,
    input  logic                 i_RESET_n,
    input  logic [DIP_WIDTH-1:0] i_DIP16,
    input  logic [SW_COUNT-1:0]  i_Switch5,
    output logic [DIP_WIDTH-1:0] o_DIP16,
    output logic [SW_COUNT-1:0]  o_Switch5,
    output logic                 o_DIPChanged,
    output logic                 o_EvValid,
    output logic [EV_WIDTH-1:0]  o_EvData,
    input  logic                 i_EvReady,
    output logic                 o_EvOverflow
);

    localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
    localparam int CNT_W = $clog2(STABLE_SAMPLES + 1);
    localparam logic [CNT_W-1:0] STABLE_CNT = CNT_W'(STABLE_SAMPLES);
    localparam logic [CNT_W-1:0] ONE_CNT    = CNT_W'(1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == STABLE_CNT) ? c : c + 1'b1;
    endfunction

    logic [DIV_W-1:0]                div_cnt;
    logic                            tick;
    logic [DIP_WIDTH-1:0]            dip_cand;
    logic [DIP_WIDTH-1:0]            dip_cand_nxt;
    logic [CNT_W-1:0]                dip_cnt;
    logic [CNT_W-1:0]                dip_cnt_nxt;
    logic [SW_COUNT-1:0]             sw_cand;
    logic [SW_COUNT-1:0]             sw_cand_nxt;
    logic [SW_COUNT-1:0][CNT_W-1:0]  sw_cnt;
    logic [SW_COUNT-1:0][CNT_W-1:0]  sw_cnt_nxt;
    logic [SW_COUNT-1:0]             sw_nxt;
    logic [SW_COUNT-1:0]             sw_flip;
    logic [SW_COUNT-1:0]             pending;
    logic [SW_COUNT-1:0]             push_mask;
    logic [EV_IDX_W-1:0]             push_idx;
    logic                            push;
    event_t                          push_ev;
    logic                            fifo_full;
    logic                            fifo_empty;

    assign tick = (div_cnt == DIV_LAST);

    // Next debounce state, committed only on a tick.
    always_comb begin
        dip_cand_nxt = dip_cand;
        dip_cnt_nxt  = dip_cnt;
        if (i_DIP16 == dip_cand) begin
            dip_cnt_nxt = sat_inc(dip_cnt);
        end else begin
            dip_cand_nxt = i_DIP16;
            dip_cnt_nxt  = ONE_CNT;
        end

        sw_cand_nxt = sw_cand;
        sw_cnt_nxt  = sw_cnt;
        sw_nxt      = o_Switch5;
        for (int b = 0; b < SW_COUNT; b++) begin
            if (i_Switch5[b] == sw_cand[b]) begin
                sw_cnt_nxt[b] = sat_inc(sw_cnt[b]);
            end else begin
                sw_cand_nxt[b] = i_Switch5[b];
                sw_cnt_nxt[b]  = ONE_CNT;
            end
            if (sw_cnt_nxt[b] == STABLE_CNT) sw_nxt[b] = sw_cand_nxt[b];
        end
        sw_flip = tick ? (sw_nxt ^ o_Switch5) : '0;
    end

    // Serializer: lowest pending index wins; nothing moves while full.
    always_comb begin
        push_mask = pending & (~pending + 1'b1);
        if (fifo_full) push_mask = '0;
        push_idx = '0;
        for (int b = 0; b < SW_COUNT; b++) begin
            if (push_mask[b]) push_idx = EV_IDX_W'(b);
        end
    end

    assign push    = |push_mask;
    // The event reports the debounced level at push time, so a bit that
    // flipped twice while queued still yields one event with its latest value.
    assign push_ev = make_event(o_Switch5[push_idx] ? EV_PRESS : EV_RELEASE,
                                push_idx);

    always_ff @(posedge i_CLK or negedge i_RESET_n) begin
        if (!i_RESET_n) begin
            div_cnt      <= '0;
            dip_cand     <= '0;
            dip_cnt      <= '0;
            sw_cand      <= '0;
            sw_cnt       <= '0;
            pending      <= '0;
            o_DIP16      <= '0;
            o_Switch5    <= '0;
            o_DIPChanged <= 1'b0;
            o_EvOverflow <= 1'b0;
        end else begin
            div_cnt      <= tick ? '0 : div_cnt + 1'b1;
            o_DIPChanged <= 1'b0;
            o_EvOverflow <= 1'b0;
            if (tick) begin
                dip_cand  <= dip_cand_nxt;
                dip_cnt   <= dip_cnt_nxt;
                sw_cand   <= sw_cand_nxt;
                sw_cnt    <= sw_cnt_nxt;
                o_Switch5 <= sw_nxt;
                if (dip_cnt_nxt == STABLE_CNT && dip_cand_nxt != o_DIP16) begin
                    o_DIP16      <= dip_cand_nxt;
                    o_DIPChanged <= 1'b1;
                end
                // A flag being pushed this very cycle is not a loss: the
                // new flip re-arms it and produces its own event later.
                o_EvOverflow <= |(sw_flip & pending & ~push_mask);
            end
            pending <= (pending & ~push_mask) | sw_flip;
        end
    end

    dip_event_fifo #(
        .WIDTH (EV_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (i_CLK),
        .rst_n     (i_RESET_n),
        .push      (push),
        .push_data (push_ev),
        .ready     (i_EvReady),
        .head      (o_EvData),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign o_EvValid = !fifo_empty;

endmodule

// File: tb/tb_dip_input_conditioner.sv
module tb_dip_input_conditioner;

    localparam int SAMPLE_DIV = 24;
    localparam int STABLE     = 4;
    localparam int DEPTH      = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] dip_in = '0;
    logic [4:0]  sw_in = '0;
    logic        ev_ready = 1'b0;
    logic        rand_ready = 1'b0;

    logic [15:0] dip_out;
    logic [4:0]  sw_out;
    logic        dip_chg;
    logic        ev_valid;
    logic [3:0]  ev_data;
    logic        ev_ovf;

    int checks = 0;
    int errors = 0;

    dip_input_conditioner #(
        .SAMPLE_DIV     (SAMPLE_DIV),
        .STABLE_SAMPLES (STABLE),
        .FIFO_DEPTH     (DEPTH)
    ) dut (
        .i_CLK        (clk),
        .i_RESET_n    (rst_n),
        .i_DIP16      (dip_in),
        .i_Switch5    (sw_in),
        .o_DIP16      (dip_out),
        .o_Switch5    (sw_out),
        .o_DIPChanged (dip_chg),
        .o_EvValid    (ev_valid),
        .o_EvData     (ev_data),
        .i_EvReady    (ev_ready),
        .o_EvOverflow (ev_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a value is accepted once the last STABLE tick samples
    // agree; switch transitions queue events in index order.
    logic [15:0] m_dip;
    logic [4:0]  m_sw, m_pend, new_sw, flips;
    logic        m_chg, m_ovf;
    logic [15:0] hist_dip[$];
    logic [4:0]  hist_sw[$];
    logic [3:0]  m_fifo[$];
    logic [3:0]  exp_q[$];
    int          cyc;
    int          ovf_seen = 0;
    bit          tick, pre_full, do_pop, same;
    int          pidx;
    logic [3:0]  ev;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_dip = '0; m_sw = '0; m_pend = '0; m_chg = 0; m_ovf = 0;
            hist_dip.delete(); hist_sw.delete(); m_fifo.delete(); exp_q.delete();
            cyc = 0;
        end else begin
            tick     = (cyc % SAMPLE_DIV) == SAMPLE_DIV - 1;
            pre_full = m_fifo.size() >= DEPTH;
            do_pop   = (m_fifo.size() > 0) && ev_ready;
            pidx = -1;
            if (!pre_full)
                for (int b = 4; b >= 0; b--) if (m_pend[b]) pidx = b;
            new_sw = m_sw; m_chg = 0;
            if (tick) begin
                hist_dip.push_back(dip_in);
                hist_sw.push_back(sw_in);
                if (hist_dip.size() > STABLE) begin
                    void'(hist_dip.pop_front());
                    void'(hist_sw.pop_front());
                end
                if (hist_dip.size() == STABLE) begin
                    same = 1;
                    for (int k = 1; k < STABLE; k++) if (hist_dip[k] != hist_dip[0]) same = 0;
                    if (same && hist_dip[0] != m_dip) begin
                        m_dip = hist_dip[0];
                        m_chg = 1;
                    end
                    for (int b = 0; b < 5; b++) begin
                        same = 1;
                        for (int k = 1; k < STABLE; k++)
                            if (hist_sw[k][b] != hist_sw[0][b]) same = 0;
                        if (same) new_sw[b] = hist_sw[0][b];
                    end
                end
            end
            flips = new_sw ^ m_sw;
            if (do_pop) void'(m_fifo.pop_front());
            if (pidx >= 0) begin
                ev = {m_sw[pidx], 3'(pidx)};
                m_fifo.push_back(ev);
                exp_q.push_back(ev);
                m_pend[pidx] = 1'b0;
            end
            m_ovf  = |(flips & m_pend);
            m_pend = m_pend | flips;
            m_sw   = new_sw;
            cyc++;
        end
    end

    // Monitor: compares outputs mid-cycle and scores every accepted event.
    always @(negedge clk) begin
        if (rst_n) begin
            check("dip16", dip_out, m_dip);
            check("switch5", sw_out, m_sw);
            check("dip_changed", dip_chg, m_chg);
            check("overflow", ev_ovf, m_ovf);
            check("ev_valid", ev_valid, m_fifo.size() != 0);
            if (ev_valid && ev_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_event: got 0x%0h expected none at %0t", ev_data, $time);
                end else begin
                    check("ev_data", ev_data, exp_q.pop_front());
                end
            end
            if (ev_ovf) ovf_seen++;
        end
    end

    always @(posedge clk) begin
        if (rand_ready) begin
            #1;
            ev_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_ticks(input int n);
        wait_cycles(n * SAMPLE_DIV);
    endtask

    task automatic drain();
        ev_ready = 1'b1;
        for (int i = 0; i < 300 && ev_valid; i++) wait_cycles(1);
        check("drain_done", ev_valid, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_dip16"}, dip_out, 16'h0);
        check({tag, "_switch5"}, sw_out, 5'h0);
        check({tag, "_dipchg"}, dip_chg, 1'b0);
        check({tag, "_valid"}, ev_valid, 1'b0);
        check({tag, "_data"}, ev_data, 4'h0);
        check({tag, "_ovf"}, ev_ovf, 1'b0);
    endtask

    initial begin
        int ovf_before;
        #1 rst_n = 1'b0;
        #1 check_all_zero("reset");
        wait_cycles(3);
        rst_n = 1'b1;

        // Single press, acceptance exactly on edge 95.
        sw_in = 5'b00100;
        repeat (95) @(posedge clk);
        #1 check("press_before_95", sw_out, 5'b00000);
        wait_cycles(1);
        check("press_at_95", sw_out, 5'b00100);
        check("press_valid_late", ev_valid, 1'b0);
        wait_cycles(1);
        check("press_valid", ev_valid, 1'b1);
        check("press_data", ev_data, 4'b1010);
        wait_cycles(20);
        check("press_data_held", ev_data, 4'b1010);
        drain();

        // Bouncing bit 0, then held high.
        for (int i = 0; i < 10; i++) begin
            sw_in[0] = ~sw_in[0];
            wait_ticks(1);
        end
        sw_in[0] = 1'b1;
        wait_ticks(6);
        check("bounce_sw", sw_out, 5'b00101);
        sw_in = '0;
        wait_ticks(6);
        drain();

        // All switches pressed with the consumer stalled.
        ev_ready = 1'b0;
        sw_in = 5'b11111;
        wait_ticks(6);
        check("all_fifo_head", ev_data, 4'b1000);
        drain();
        sw_in = '0;
        wait_ticks(6);
        drain();

        // DIP word change and a short glitch.
        dip_in = 16'hA5C3;
        wait_ticks(6);
        check("dip_new", dip_out, 16'hA5C3);
        dip_in = 16'hFFFF;
        wait_ticks(2);
        dip_in = 16'hA5C3;
        wait_ticks(6);
        check("dip_glitch", dip_out, 16'hA5C3);

        // Overflow: FIFO full, bit 1 pending, bit 1 released again.
        ev_ready = 1'b0;
        sw_in = 5'b11101;
        wait_ticks(6);
        sw_in = 5'b11111;
        wait_ticks(6);
        ovf_before = ovf_seen;
        sw_in = 5'b11101;
        wait_ticks(6);
        check("ovf_count", ovf_seen - ovf_before, 1);
        drain();
        sw_in = '0;
        wait_ticks(6);
        drain();

        // Reset in the middle of debouncing with events queued.
        ev_ready = 1'b0;
        sw_in = 5'b00111;
        wait_ticks(6);
        sw_in = '0;
        wait_ticks(2);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check_all_zero("midreset");
        dip_in = '0;
        wait_cycles(3);
        rst_n = 1'b1;
        ev_ready = 1'b1;
        wait_ticks(6);
        check("post_reset_valid", ev_valid, 1'b0);

        // Randomized traffic.
        rand_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            sw_in = 5'($urandom);
            dip_in = ($urandom_range(0, 1) != 0) ? 16'(($urandom & 32'h3) * 32'h1111) : dip_in;
            wait_cycles($urandom_range(10, 150));
        end
        rand_ready = 1'b0;
        wait_cycles(2);
        drain();
        check("scoreboard_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dip_input_conditioner.md
# dip_input_conditioner

Debounces and event-encodes the DIP/switch words produced by the serial DIP parallelizer, sitting directly downstream of it. It samples the 16-bit DIP word and the 5 push-switches at a fixed frame rate, publishes stable values only after a configurable number of identical samples, and emits press/release events for the switches through a small valid/ready event FIFO. The block feeds the CPU front panel and control logic.

## Interface
- `SAMPLE_DIV`, default 24: clocks per sample tick; matches one parallelizer frame.
- `STABLE_SAMPLES`, default 4: consecutive identical samples required to accept a value; legal range ≥ 2.
- `FIFO_DEPTH`, default 4: event FIFO entries; must be a power of two.
- `i_CLK`, in, 1: single clock; all state is on its rising edge.
- `i_RESET_n`, in, 1: reset, asynchronous and active-low.
- `i_DIP16`, in, 16: raw DIP word from the parallelizer.
- `i_Switch5`, in, 5: raw switch bits from the parallelizer.
- `o_DIP16`, out, 16: debounced DIP word.
- `o_Switch5`, out, 5: debounced switch bits.
- `o_DIPChanged`, out, 1: one-cycle pulse when `o_DIP16` updates to a different value.
- `o_EvValid`, out, 1: FIFO head is valid.
- `o_EvData`, out, 4: event at the FIFO head, `{kind, idx[2:0]}`. `kind` 1 means press (0→1); `kind` 0 means release (1→0).
- `i_EvReady`, in, 1: consumer accepts the head when high together with `o_EvValid`.
- `o_EvOverflow`, out, 1: one-cycle pulse when an event is lost.

## Operation
- **Sample divider.**
  - Counter runs 0..`SAMPLE_DIV`-1 and wraps.
  - `tick` is high in the cycle where the counter equals `SAMPLE_DIV`-1.
- **DIP debounce, whole word.**
  - On `tick`, if `i_DIP16` equals the candidate, increment the count, saturating at `STABLE_SAMPLES`.
  - Otherwise load `i_DIP16` into the candidate and set the count to 1.
  - If the post-update count equals `STABLE_SAMPLES` and the candidate differs from `o_DIP16`: load `o_DIP16` and pulse `o_DIPChanged`.
- **Switch debounce, per bit.** Each bit has its own candidate and counter and follows the same rule independently.
  - When a bit of `o_Switch5` flips, set the corresponding bit in a 5-bit `pending` mask.
- **Event serializer.**
  - Each cycle, if `pending` is non-zero and the FIFO is not full, push the event for the lowest set index and clear that pending bit.
  - The event is `kind` = current `o_Switch5[idx]`, `idx` = the bit index.
  - If a tick flips a bit whose pending flag is still set: pulse `o_EvOverflow` and leave the flag set. Only one event is produced, reflecting the value at push time.
- **FIFO.**
  - Pop on `o_EvValid & i_EvReady`.
  - Push is blocked while full, even when a pop occurs in the same cycle.
  - Simultaneous push and pop on a non-full, non-empty FIFO leaves the occupancy unchanged.
  - Entries are delivered in push order.
- **Reset, asynchronous, including mid-operation.** All of the following clear to 0 immediately:
  - counters and candidates
  - `pending` and FIFO occupancy
  - `o_DIP16`, `o_Switch5`, `o_DIPChanged`, `o_EvValid`, `o_EvData`, `o_EvOverflow`
- **Power-up.** Switches or DIPs already non-zero at reset release produce press events / `o_DIPChanged` once they are accepted.

## Timing
- The first `tick` occurs in cycle `SAMPLE_DIV`-1 after reset release (cycle 0 is the first edge).
- Debounced outputs, `o_DIPChanged` and `pending` update on the tick edge E.
- The first event is pushed at edge E+1. `o_EvValid` is high from E+1 until drained.
- Each further pending event is pushed one per cycle.
- Acceptance latency from a held input change is between (`STABLE_SAMPLES`-1)·`SAMPLE_DIV`+1 and `STABLE_SAMPLES`·`SAMPLE_DIV` cycles.
- `o_EvData` is stable while `o_EvValid` is high and not accepted.

## Structure
- **Package `dip_input_pkg`** holds:
  - `DIP_WIDTH`=16, `SW_COUNT`=5, `EV_WIDTH`=4
  - `EV_PRESS`=1, `EV_RELEASE`=0
  - the event field slice constants
- **Sub-module `dip_event_fifo`:** synchronous FIFO parameterized by width and depth, with full/empty flags and a valid/ready head.

## Test plan
1. **Single press.** Reset, then hold `i_Switch5`=5'b00100 → `o_Switch5`=5'b00100 at the edge of cycle 95. Exactly one event, `o_EvData`=4'b1010, is held until `i_EvReady`=1.
2. **Bouncing bit.** Bit0 alternates every tick for 10 ticks, then stays 1 → nothing while it alternates. Exactly one event, 4'b1000, follows the 4th consecutive sample of 1.
3. **All switches pressed.** All five pressed together with `i_EvReady`=0 → the FIFO holds idx 0..3 and idx 4 stays pending. Raising `i_EvReady` drains 4'b1000, 1001, 1010, 1011, 1100 in that order.
4. **DIP word change.** `i_DIP16` goes 0x0000→0xA5C3 and is held → `o_DIP16`=0xA5C3 after 4 ticks, with a single one-cycle `o_DIPChanged`. A 2-tick glitch to 0xFFFF → no change and no pulse.
5. **Overflow.** FIFO full with `i_EvReady`=0 and bit1 pending; bit1 then releases and is accepted → `o_EvOverflow` pulses once. After draining, the single event delivered for idx 1 is 4'b0001.
6. **Reset mid-operation.** Assert `i_RESET_n`=0 with 3 events queued mid-debounce → all outputs 0 in the same cycle with no clock edge. After release, no stale events appear.
